oram_ctrl: RTL and testbench

// - Path-ORAM controller: 2**TREE_DEPTH logical blocks held in an on-chip binary tree of buckets.
// - Each block is tagged with a random leaf. Every access reads one root-to-leaf path into a stash,

---
 rtl/oram_pkg.sv | 54 +++++
 rtl/oram_if.sv | 21 ++
 rtl/oram_lfsr.sv | 15 +
 rtl/oram_ctrl.sv | 157 +++++++++++++++
 tb/tb_oram_ctrl.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/oram_pkg.sv
// rtl/oram_pkg.sv - Path-ORAM geometry constants, slot struct, FSM states and path-indexing helpers.
package oram_pkg;
  localparam int TREE_DEPTH      = 4;
  localparam int BYTE_WIDTH      = 8;
  localparam int BYTES_PER_BLOCK = 4;
  localparam int BUCKET_SIZE     = 4;
  localparam int STASH_SIZE      = 16;

  localparam int DATA_W      = BYTE_WIDTH * BYTES_PER_BLOCK;
  localparam int LEAF_W      = TREE_DEPTH - 1;
  localparam int NUM_BLOCKS  = 1 << TREE_DEPTH;
  localparam int NUM_BUCKETS = (1 << TREE_DEPTH) - 1;
  localparam int NUM_SLOTS   = NUM_BUCKETS * BUCKET_SIZE;
  localparam int PATH_SLOTS  = TREE_DEPTH * BUCKET_SIZE;
  localparam int SLOT_IDX_W  = $clog2(NUM_SLOTS);
  localparam int STASH_IDX_W = $clog2(STASH_SIZE);
  localparam int CNT_W       = $clog2(PATH_SLOTS);

  typedef struct packed {
    logic                  valid;
    logic [TREE_DEPTH-1:0] tag;
    logic [LEAF_W-1:0]     leaf;
    logic [DATA_W-1:0]     data;
  } slot_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    READ_PATH,
    UPDATE,
    WRITE_PATH,
    DONE
  } state_t;

  function automatic logic [NUM_BLOCKS*LEAF_W-1:0] posmap_init();
    logic [NUM_BLOCKS*LEAF_W-1:0] v;
    v = '0;
    for (int b = 0; b < NUM_BLOCKS; b++) v[b*LEAF_W +: LEAF_W] = LEAF_W'(b);
    return v;
  endfunction

  localparam logic [NUM_BLOCKS*LEAF_W-1:0] POSMAP_INIT = posmap_init();

  // Heap layout: bucket (1<<l)-1 + (leaf >> (L-1-l)), Z consecutive slots per bucket.
  function automatic logic [SLOT_IDX_W-1:0] slot_index(logic [LEAF_W-1:0] leaf, int level, int slot);
    int bucket;
    bucket = (1 << level) - 1 + int'(leaf >> (LEAF_W - level));
    return SLOT_IDX_W'(bucket * BUCKET_SIZE + slot);
  endfunction

  function automatic logic prefix_match(logic [LEAF_W-1:0] a, logic [LEAF_W-1:0] b, int level);
    return (a >> (LEAF_W - level)) == (b >> (LEAF_W - level));
  endfunction
endpackage

// File: rtl/oram_if.sv
// rtl/oram_if.sv - Client request/response bundle of the Path-ORAM controller.
interface oram_if;
  import oram_pkg::*;

  logic [TREE_DEPTH-1:0] block_num;
  logic [DATA_W-1:0]     write_val;
  logic                  rw_indicator;
  logic                  input_ready;
  logic [DATA_W-1:0]     read_val;
  logic                  output_ready;

  modport master (
    output block_num, write_val, rw_indicator, input_ready,
    input  read_val, output_ready
  );

  modport slave (
    input  block_num, write_val, rw_indicator, input_ready,
    output read_val, output_ready
  );
endinterface

// File: rtl/oram_lfsr.sv
// rtl/oram_lfsr.sv - Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying fresh leaf labels.
module oram_lfsr #(
  parameter int OUT_W = 3
) (
  input  logic             clk,
  output logic [OUT_W-1:0] leaf
);
  logic [15:0] lfsr = 16'hACE1;

  always_ff @(posedge clk) begin
    lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign leaf = lfsr[OUT_W-1:0];
endmodule

// File: rtl/oram_ctrl.sv
// rtl/oram_ctrl.sv - Path-ORAM controller: tree, stash, position map and access FSM.
// Optional ORAM_STASH_CHECK_EN compiles stash-overflow / duplicate-tag / output_ready assertions.
module oram_ctrl
  import oram_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  oram_if.slave bus
);
  state_t                state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [TREE_DEPTH-1:0] req_block;
  logic [DATA_W-1:0]     req_data;
  logic                  req_write;
  logic [DATA_W-1:0]     read_val;
  logic                  output_ready;
  logic [LEAF_W-1:0]     path_leaf, remap_leaf, new_leaf;

  // Storage has no reset: contents survive rst, only power-up initialisers apply.
  slot_t                        tree  [NUM_SLOTS]  = '{default: '0};
  slot_t                        stash [STASH_SIZE] = '{default: '0};
  logic [NUM_BLOCKS*LEAF_W-1:0] posmap = POSMAP_INIT;

  oram_lfsr #(.OUT_W(LEAF_W)) u_lfsr (.clk(clk), .leaf(new_leaf));

  int                     level;
  logic [SLOT_IDX_W-1:0]  slot_idx;
  logic                   last_slot;
  logic [STASH_IDX_W-1:0] free_idx, hit_idx, elig_idx;
  logic                   stash_full, hit, elig;

  always_comb begin
    level = int'(cnt) / BUCKET_SIZE;
    if (state == WRITE_PATH) level = TREE_DEPTH - 1 - level;
    slot_idx  = slot_index(path_leaf, level, int'(cnt) % BUCKET_SIZE);
    last_slot = (cnt == CNT_W'(PATH_SLOTS - 1));
  end

  // Scan high to low so the lowest matching index wins.
  always_comb begin
    stash_full = 1'b1;
    hit        = 1'b0;
    elig       = 1'b0;
    free_idx   = '0;
    hit_idx    = '0;
    elig_idx   = '0;
    for (int i = STASH_SIZE - 1; i >= 0; i--) begin
      if (!stash[i].valid) begin
        stash_full = 1'b0;
        free_idx   = STASH_IDX_W'(i);
      end else begin
        if (stash[i].tag == req_block) begin
          hit     = 1'b1;
          hit_idx = STASH_IDX_W'(i);
        end
        if (prefix_match(stash[i].leaf, path_leaf, level)) begin
          elig     = 1'b1;
          elig_idx = STASH_IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = '0;
    case (state)
      IDLE:       if (bus.input_ready) state_next = LOOKUP;
      LOOKUP:     state_next = READ_PATH;
      READ_PATH:  if (last_slot) state_next = UPDATE; else cnt_next = cnt + CNT_W'(1);
      UPDATE:     state_next = WRITE_PATH;
      WRITE_PATH: if (last_slot) state_next = DONE; else cnt_next = cnt + CNT_W'(1);
      DONE:       if (!bus.input_ready) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      output_ready <= 1'b0;
      read_val     <= '0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      output_ready <= (state_next == DONE);
      if (state == IDLE && bus.input_ready) begin
        req_block <= bus.block_num;
        req_data  <= bus.write_val;
        req_write <= bus.rw_indicator;
      end
      if (state == UPDATE)
        read_val <= req_write ? req_data : (hit ? stash[hit_idx].data : '0);
    end
  end

  // Datapath keys on state only, so a slot move in flight when rst lands still completes.
  always_ff @(posedge clk) begin
    case (state)
      LOOKUP: begin
        path_leaf  <= posmap[int'(req_block)*LEAF_W +: LEAF_W];
        remap_leaf <= new_leaf;
        posmap[int'(req_block)*LEAF_W +: LEAF_W] <= new_leaf;
      end
      READ_PATH: begin
        if (tree[slot_idx].valid) begin
          if (!stash_full) stash[free_idx] <= tree[slot_idx];
          tree[slot_idx].valid <= 1'b0;
        end
      end
      UPDATE: begin
        if (hit) begin
          stash[hit_idx].leaf <= remap_leaf;
          if (req_write) stash[hit_idx].data <= req_data;
        end else if (req_write && !stash_full) begin
          stash[free_idx] <= '{valid: 1'b1, tag: req_block, leaf: remap_leaf, data: req_data};
        end
      end
      WRITE_PATH: begin
        if (elig) begin
          tree[slot_idx]        <= stash[elig_idx];
          stash[elig_idx].valid <= 1'b0;
        end else begin
          tree[slot_idx].valid <= 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus.read_val     = read_val;
  assign bus.output_ready = output_ready;

`ifdef ORAM_STASH_CHECK_EN
  logic overflow_try, dup_tag;

  always_comb begin
    overflow_try = stash_full &&
                   ((state == READ_PATH && tree[slot_idx].valid) ||
                    (state == UPDATE && req_write && !hit));
    dup_tag = 1'b0;
    for (int i = 0; i < STASH_SIZE; i++)
      for (int j = i + 1; j < STASH_SIZE; j++)
        if (stash[i].valid && stash[j].valid && stash[i].tag == stash[j].tag) dup_tag = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!overflow_try) else $error("oram_ctrl: stash overflow, block dropped");
      assert (!dup_tag) else $error("oram_ctrl: duplicate tag in stash");
      assert (!output_ready || state == DONE) else $error("oram_ctrl: output_ready outside DONE");
    end
  end
`else
`endif
endmodule

// File: tb/tb_oram_ctrl.sv
// tb/tb_oram_ctrl.sv - Self-checking bench for oram_ctrl against a flat block-memory reference model.
module tb_oram_ctrl;
  import oram_pkg::*;

  localparam int LATENCY = 2 * TREE_DEPTH * BUCKET_SIZE + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  oram_if bus ();
  oram_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // The ORAM must behave like a plain memory of blocks that reads 0 until first written.
  logic [DATA_W-1:0] ref_mem [NUM_BLOCKS];
  bit                ref_written [NUM_BLOCKS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_access(logic [TREE_DEPTH-1:0] blk, logic wr, logic [DATA_W-1:0] val);
    if (wr) begin
      ref_mem[blk]     = val;
      ref_written[blk] = 1'b1;
      return val;
    end
    return ref_written[blk] ? ref_mem[blk] : '0;
  endfunction

  task automatic access(input string tag, input logic [TREE_DEPTH-1:0] blk, input logic wr,
                        input logic [DATA_W-1:0] val, input int hold);
    int                lat;
    bit                stayed;
    logic [DATA_W-1:0] exp;
    exp = ref_access(blk, wr, val);
    bus.block_num    = blk;
    bus.write_val    = val;
    bus.rw_indicator = wr;
    bus.input_ready  = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.output_ready && lat < 4 * LATENCY);
    check({tag, " latency"}, 32'(lat), 32'(LATENCY));
    check({tag, " read_val"}, bus.read_val, exp);
    if (hold > 0) begin
      stayed = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        if (bus.output_ready !== 1'b1 || bus.read_val !== exp) stayed = 1'b0;
      end
      check({tag, " held in DONE"}, 32'(stayed), 32'd1);
    end
    bus.input_ready = 1'b0;
    @(posedge clk); #1;
    check({tag, " output_ready fall"}, 32'(bus.output_ready), 32'd0);
  endtask

  task automatic pulse_rst(input string tag);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check({tag, " output_ready in rst"}, 32'(bus.output_ready), 32'd0);
    check({tag, " read_val in rst"}, bus.read_val, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      ref_mem[i]     = '0;
      ref_written[i] = 1'b0;
    end
    bus.block_num    = '0;
    bus.write_val    = '0;
    bus.rw_indicator = 1'b0;
    bus.input_ready  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset output_ready", 32'(bus.output_ready), 32'd0);
    check("reset read_val", bus.read_val, 32'd0);
    rst = 1'b0;

    access("wr b1=2", 4'd1, 1'b1, 32'd2, 0);
    pulse_rst("rst1");
    access("wr b3=10", 4'd3, 1'b1, 32'd10, 0);
    pulse_rst("rst2");
    access("rd b1", 4'd1, 1'b0, 32'd0, 0);

    access("rd unwritten b5", 4'd5, 1'b0, 32'hDEAD_BEEF, 0);

    access("wr b2=7", 4'd2, 1'b1, 32'd7, 0);
    access("rd b2 first", 4'd2, 1'b0, 32'd0, 0);
    access("rd b2 second", 4'd2, 1'b0, 32'd0, 0);

    for (int i = 0; i < NUM_BLOCKS; i++) access($sformatf("fill wr b%0d", i), 4'(i), 1'b1, 32'(i * 3), 0);
    for (int i = 0; i < NUM_BLOCKS; i++) access($sformatf("fill rd b%0d", i), 4'(i), 1'b0, 32'd0, 0);

    // Start a read of block 4 and reset on the last READ_PATH cycle, keeping the request high.
    bus.block_num    = 4'd4;
    bus.write_val    = '0;
    bus.rw_indicator = 1'b0;
    bus.input_ready  = 1'b1;
    @(posedge clk);
    repeat (PATH_SLOTS) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("mid-access rst output_ready", 32'(bus.output_ready), 32'd0);
    end
    check("mid-access rst read_val", bus.read_val, 32'd0);
    rst = 1'b0;
    access("rd b4 after mid rst", 4'd4, 1'b0, 32'd0, 0);

    access("wr b6 hold", 4'd6, 1'b1, 32'h0000_0099, 20);
    access("rd b6 after hold", 4'd6, 1'b0, 32'd0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [TREE_DEPTH-1:0] blk;
      logic                  wr;
      logic [DATA_W-1:0]     val;
      blk = TREE_DEPTH'($urandom_range(0, NUM_BLOCKS - 1));
      wr  = 1'($urandom_range(0, 1));
      val = $urandom;
      access($sformatf("rand%0d %s b%0d", n, wr ? "wr" : "rd", blk), blk, wr, val, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
